// File: rtl/medfilt_pkg.sv
// rtl/medfilt_pkg.sv - shared types and helpers for the median filter stream controller
// Contents:
//   ctrl_state_e     sequencer state (IDLE / RUN / FLUSH)
//   default_latency  core latency in ce steps for a given line width (2*W+12)
package medfilt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } ctrl_state_e;

   function automatic int default_latency(input int w);
      return 2 * w + 12;
   endfunction

endpackage

// File: rtl/medfilt_frame_cnt.sv
// rtl/medfilt_frame_cnt.sv - horizontal/vertical pixel position counter with enable and frame wrap
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_en        advance one pixel position
//   o_first     position is (0,0)
//   o_eol       position is the last pixel of a line
//   o_last      position is the last pixel of the frame
module medfilt_frame_cnt #(
   parameter int W = 8,
   parameter int H = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output logic o_first,
   output logic o_eol,
   output logic o_last
);

   localparam int HW = (W > 1) ? $clog2(W) : 1;
   localparam int VW = (H > 1) ? $clog2(H) : 1;

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   logic          w_eol;
   logic          w_eof_line;

   assign w_eol      = (r_hcnt == HW'(W - 1));
   assign w_eof_line = (r_vcnt == VW'(H - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (i_en) begin
         if (w_eol) begin
            r_hcnt <= '0;
            r_vcnt <= w_eof_line ? '0 : r_vcnt + VW'(1);
         end else begin
            r_hcnt <= r_hcnt + HW'(1);
         end
      end
   end

   assign o_first = (r_hcnt == '0) && (r_vcnt == '0);
   assign o_eol   = w_eol;
   assign o_last  = w_eol && w_eof_line;

endmodule

// File: rtl/medfilt_stream_ctrl.sv
// rtl/medfilt_stream_ctrl.sv - frame sequencer and AXI-Stream boundary for the 3x3 median filter core
// Optional build macro: MEDFILT_CTRL_STATUS_EN builds the err/frame_done/frame_cnt logic;
// without it those outputs are tied to 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_s_axis_*        input pixel stream (tuser = SOF, tlast = EOL), o_s_axis_tready
//   o_m_axis_*        filtered pixel stream, tuser/tlast regenerated here, i_m_axis_tready
//   o_core_ce         core advance strobe (one pixel step per high cycle)
//   o_core_din        pixel into core (0 while flushing)
//   o_core_sof        high with the first ce of a frame
//   i_core_dout       core result, held between ce pulses
//   o_frame_done      one-cycle pulse after the last output beat of a frame
//   o_err_sof/o_err_eol  sticky protocol flags
//   o_frame_cnt       completed output frames (wraps)
module medfilt_stream_ctrl
   import medfilt_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 512,
   parameter int LATENCY      = default_latency(FRAME_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] i_s_axis_tdata,
   input  logic                  i_s_axis_tvalid,
   output logic                  o_s_axis_tready,
   input  logic                  i_s_axis_tuser,
   input  logic                  i_s_axis_tlast,
   output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
   output logic                  o_m_axis_tvalid,
   input  logic                  i_m_axis_tready,
   output logic                  o_m_axis_tuser,
   output logic                  o_m_axis_tlast,
   output logic                  o_core_ce,
   output logic [DATA_WIDTH-1:0] o_core_din,
   output logic                  o_core_sof,
   input  logic [DATA_WIDTH-1:0] i_core_dout,
   output logic                  o_frame_done,
   output logic                  o_err_sof,
   output logic                  o_err_eol,
   output logic [15:0]           o_frame_cnt
);

   localparam int N_STEPS = FRAME_WIDTH * FRAME_HEIGHT + LATENCY;
   localparam int STEP_W  = $clog2(N_STEPS);

   ctrl_state_e       r_state;
   logic [STEP_W-1:0] r_n;
   logic              r_m_tvalid;

   logic w_out_free;
   logic w_m_fire;
   logic w_s_tready;
   logic w_ce;
   logic w_pix_ce;
   logic w_step_last;
   logic w_produce;
   logic w_in_first, w_in_eol, w_in_last;
   logic w_out_first, w_out_eol, w_out_last;

   assign w_out_free = !r_m_tvalid || i_m_axis_tready;
   assign w_m_fire   = r_m_tvalid && i_m_axis_tready;

   // An SOF beat is only taken in IDLE when its ce can issue; non-SOF beats are dropped freely.
   always_comb begin
      w_s_tready = 1'b0;
      w_ce       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_s_tready = !i_s_axis_tuser || w_out_free;
            w_ce       = i_s_axis_tvalid && i_s_axis_tuser && w_out_free;
         end
         ST_RUN: begin
            w_s_tready = w_out_free;
            w_ce       = i_s_axis_tvalid && w_out_free;
         end
         ST_FLUSH: begin
            w_ce = w_out_free;
         end
         default: ;
      endcase
   end

   // ce that consumes a real input pixel (as opposed to a flush step)
   assign w_pix_ce    = w_ce && (r_state != ST_FLUSH);
   assign w_step_last = (r_n == STEP_W'(N_STEPS - 1));
   assign w_produce   = w_ce && (r_n >= STEP_W'(LATENCY));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_n        <= '0;
         r_m_tvalid <= 1'b0;
      end else begin
         if (w_ce) begin
            r_n <= w_step_last ? '0 : r_n + STEP_W'(1);
         end
         // A producing ce only issues when out_free, so it overrides a simultaneous m_fire.
         if (w_produce) begin
            r_m_tvalid <= 1'b1;
         end else if (w_m_fire) begin
            r_m_tvalid <= 1'b0;
         end
         case (r_state)
            ST_IDLE:  if (w_ce) r_state <= ST_RUN;
            ST_RUN:   if (w_pix_ce && w_in_last) r_state <= ST_FLUSH;
            ST_FLUSH: if (w_ce && w_step_last) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   medfilt_frame_cnt #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_in_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_pix_ce),
      .o_first (w_in_first),
      .o_eol   (w_in_eol),
      .o_last  (w_in_last)
   );

   medfilt_frame_cnt #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_out_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_m_fire),
      .o_first (w_out_first),
      .o_eol   (w_out_eol),
      .o_last  (w_out_last)
   );

   assign o_s_axis_tready = w_s_tready;
   assign o_core_ce       = w_ce;
   assign o_core_sof      = w_ce && (r_state == ST_IDLE);
   assign o_core_din      = (r_state == ST_FLUSH) ? '0 : i_s_axis_tdata;
   assign o_m_axis_tdata  = i_core_dout;
   assign o_m_axis_tvalid = r_m_tvalid;
   assign o_m_axis_tuser  = w_out_first;
   assign o_m_axis_tlast  = w_out_eol;

   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, w_in_first};

`ifdef MEDFILT_CTRL_STATUS_EN
   logic        w_s_fire;
   logic        r_err_sof;
   logic        r_err_eol;
   logic        r_frame_done;
   logic [15:0] r_frame_cnt;

   assign w_s_fire = i_s_axis_tvalid && w_s_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_sof    <= 1'b0;
         r_err_eol    <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         // Dropped non-SOF beat in IDLE, or a stray SOF inside a frame
         if (w_s_fire && (((r_state == ST_IDLE) && !i_s_axis_tuser) ||
                          ((r_state == ST_RUN) && i_s_axis_tuser))) begin
            r_err_sof <= 1'b1;
         end
         if (w_pix_ce && (i_s_axis_tlast != w_in_eol)) begin
            r_err_eol <= 1'b1;
         end
         r_frame_done <= w_m_fire && w_out_last;
         if (w_m_fire && w_out_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign o_err_sof    = r_err_sof;
   assign o_err_eol    = r_err_eol;
   assign o_frame_done = r_frame_done;
   assign o_frame_cnt  = r_frame_cnt;
`else
   logic w_unused_status_ok;
   assign w_unused_status_ok = &{1'b0, i_s_axis_tlast, w_in_eol, w_out_last};

   assign o_err_sof    = 1'b0;
   assign o_err_eol    = 1'b0;
   assign o_frame_done = 1'b0;
   assign o_frame_cnt  = '0;
`endif

endmodule

// File: tb/tb_medfilt_stream_ctrl.sv
// tb/tb_medfilt_stream_ctrl.sv - self-checking bench for medfilt_stream_ctrl with a delay-line core stub
module tb_medfilt_stream_ctrl;

   localparam int DW   = 8;
   localparam int W    = 8;
   localparam int H    = 4;
   localparam int L    = 4;
   localparam int NPIX = W * H;
`ifdef MEDFILT_CTRL_STATUS_EN
   localparam logic [31:0] STATUS_EN = 32'd1;
`else
   localparam logic [31:0] STATUS_EN = 32'd0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tuser = 1'b0;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tuser;
   logic          m_tlast;
   logic          core_ce;
   logic [DW-1:0] core_din;
   logic          core_sof;
   logic [DW-1:0] core_dout;
   logic          frame_done;
   logic          err_sof;
   logic          err_eol;
   logic [15:0]   frame_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   medfilt_stream_ctrl #(
      .DATA_WIDTH   (DW),
      .FRAME_WIDTH  (W),
      .FRAME_HEIGHT (H),
      .LATENCY      (L)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_s_axis_tdata  (s_tdata),
      .i_s_axis_tvalid (s_tvalid),
      .o_s_axis_tready (s_tready),
      .i_s_axis_tuser  (s_tuser),
      .i_s_axis_tlast  (s_tlast),
      .o_m_axis_tdata  (m_tdata),
      .o_m_axis_tvalid (m_tvalid),
      .i_m_axis_tready (m_tready),
      .o_m_axis_tuser  (m_tuser),
      .o_m_axis_tlast  (m_tlast),
      .o_core_ce       (core_ce),
      .o_core_din      (core_din),
      .o_core_sof      (core_sof),
      .i_core_dout     (core_dout),
      .o_frame_done    (frame_done),
      .o_err_sof       (err_sof),
      .o_err_eol       (err_eol),
      .o_frame_cnt     (frame_cnt)
   );

   // Core stub: after ce step n, dout holds the pixel fed at step n-L.
   logic [DW-1:0] core_pipe [0:L];
   always @(posedge clk) begin
      if (core_ce) begin
         core_pipe[0] <= core_din;
         for (int i = 1; i <= L; i++) core_pipe[i] <= core_pipe[i-1];
      end
   end
   assign core_dout = core_pipe[L];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference model: accepted frames appear on the output in order; framing follows output position.
   logic [DW-1:0] exp_q [$];
   int            out_idx    = 0;
   int            out_total  = 0;
   int            ce_total   = 0;
   int            sof_total  = 0;
   int            done_total = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;
   logic [DW-1:0] exp_px;

   always @(negedge clk) begin
      if (rst_n) begin
         if (core_ce)    ce_total++;
         if (core_sof)   sof_total++;
         if (frame_done) done_total++;
         if (prev_stall) begin
            chk("hold_tvalid", 32'(m_tvalid), 32'd1);
            chk("hold_tdata", 32'(m_tdata), 32'(prev_data));
         end
         if (m_tvalid && m_tready) begin
            chk("no_extra_beat", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_px = exp_q.pop_front();
               chk("out_tdata", 32'(m_tdata), 32'(exp_px));
               chk("out_tuser", 32'(m_tuser), 32'(out_idx == 0));
               chk("out_tlast", 32'(m_tlast), 32'((out_idx % W) == W - 1));
            end
            out_idx = (out_idx + 1) % NPIX;
            out_total++;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Output back-pressure pattern: 0 = always ready, 1 = toggle, 2 = random
   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l, input int max_gap);
      int   budget;
      logic acc;
      s_tvalid = 1'b0;
      repeat ($urandom_range(0, max_gap)) begin
         @(posedge clk);
         #1;
      end
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      budget   = 200;
      acc      = 1'b0;
      while (!acc && budget > 0) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         budget--;
      end
      chk("beat_accepted", 32'(acc), 32'd1);
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int max_gap, input int bad_eol_beat);
      logic [DW-1:0] px [NPIX];
      for (int i = 0; i < NPIX; i++) begin
         px[i] = DW'($urandom);
         exp_q.push_back(px[i]);
      end
      for (int i = 0; i < NPIX; i++) begin
         send_beat(px[i], i == 0, ((i % W) == W - 1) || (i == bad_eol_beat), max_gap);
      end
   endtask

   task automatic wait_out(input int target);
      int budget = 3000;
      while (out_total < target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("drain_done", 32'(out_total >= target), 32'd1);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   int ce0;
   int sof0;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_core_ce", 32'(core_ce), 32'd0);
      chk("rst_core_sof", 32'(core_sof), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_err_sof", 32'(err_sof), 32'd0);
      chk("rst_err_eol", 32'(err_eol), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single frame, full throughput
      rdy_mode = 0;
      ce0 = ce_total; sof0 = sof_total;
      send_frame(0, -1);
      wait_out(NPIX);
      chk("f1_ce_count", 32'(ce_total - ce0), 32'(NPIX + L));
      chk("f1_sof_count", 32'(sof_total - sof0), 32'd1);
      chk("f1_out_count", 32'(out_total), 32'(NPIX));
      chk("f1_frame_done", 32'(done_total), STATUS_EN);
      chk("f1_frame_cnt", 32'(frame_cnt), STATUS_EN);
      chk("f1_err_sof", 32'(err_sof), 32'd0);
      chk("f1_idle_tvalid", 32'(m_tvalid), 32'd0);

      // Non-SOF beats in IDLE are discarded
      ce0 = ce_total;
      for (int i = 0; i < 3; i++) send_beat(DW'($urandom), 1'b0, 1'b0, 0);
      chk("garbage_no_ce", 32'(ce_total - ce0), 32'd0);
      chk("garbage_err_sof", 32'(err_sof), STATUS_EN);
      ce0 = ce_total;
      send_frame(0, -1);
      wait_out(2 * NPIX);
      chk("f2_ce_count", 32'(ce_total - ce0), 32'(NPIX + L));
      chk("f2_frame_cnt", 32'(frame_cnt), 2 * STATUS_EN);
      chk("f2_err_eol", 32'(err_eol), 32'd0);

      // Toggling output ready with random input gaps
      rdy_mode = 1;
      ce0 = ce_total;
      send_frame(3, -1);
      wait_out(3 * NPIX);
      chk("f3_ce_count", 32'(ce_total - ce0), 32'(NPIX + L));
      chk("f3_err_eol", 32'(err_eol), 32'd0);
      chk("f3_frame_cnt", 32'(frame_cnt), 3 * STATUS_EN);

      // Misplaced tlast on input beat 5
      rdy_mode = 0;
      send_frame(0, 5);
      wait_out(4 * NPIX);
      chk("f4_err_eol", 32'(err_eol), STATUS_EN);
      chk("f4_frame_cnt", 32'(frame_cnt), 4 * STATUS_EN);

      // Back-to-back frames with random output ready
      rdy_mode = 2;
      ce0 = ce_total; sof0 = sof_total;
      send_frame(0, -1);
      send_frame(0, -1);
      wait_out(6 * NPIX);
      chk("b2b_ce_count", 32'(ce_total - ce0), 32'(2 * (NPIX + L)));
      chk("b2b_sof_count", 32'(sof_total - sof0), 32'd2);
      chk("b2b_frame_cnt", 32'(frame_cnt), 6 * STATUS_EN);
      chk("b2b_frame_done", 32'(done_total), 6 * STATUS_EN);

      // Reset while the flush is in progress
      rdy_mode = 0;
      send_frame(0, -1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("mid_rst_core_ce", 32'(core_ce), 32'd0);
      chk("mid_rst_core_sof", 32'(core_sof), 32'd0);
      chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
      chk("mid_rst_err_sof", 32'(err_sof), 32'd0);
      chk("mid_rst_err_eol", 32'(err_eol), 32'd0);
      chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      exp_q.delete();
      out_idx    = 0;
      out_total  = 0;
      done_total = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ce0 = ce_total;
      send_frame(0, -1);
      wait_out(NPIX);
      chk("post_rst_ce_count", 32'(ce_total - ce0), 32'(NPIX + L));
      chk("post_rst_frame_cnt", 32'(frame_cnt), STATUS_EN);
      chk("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
